// File: rtl/edge_evt_pkg.sv
// Shared encodings for the edge event scheduler: channel edge modes and event kind.
// Also carries the modulo helper used by the round-robin arbiter.
package edge_evt_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_e;

  localparam logic KIND_FALL = 1'b0;
  localparam logic KIND_RISE = 1'b1;

  function automatic int rr_wrap(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/edge_qualifier.sv
// Per-channel synchronizer + history flop; flags a mode-qualified edge SYNC_STAGES cycles
// after a stable input change. No backpressure: the edge pulse lasts exactly one cycle.
module edge_qualifier
  import edge_evt_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig,
  input  logic [1:0] mode,
  input  logic       arm,
  output logic       hit,
  output logic       kind
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   synced;
  logic                   rise;
  logic                   fall;
  logic                   rise_en;
  logic                   fall_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign synced  = sync_q[SYNC_STAGES-1];
  assign rise    = synced & ~hist_q;
  assign fall    = ~synced & hist_q;
  assign rise_en = (mode == MODE_RISE) || (mode == MODE_BOTH);
  assign fall_en = (mode == MODE_FALL) || (mode == MODE_BOTH);

  // arm holds off qualification until the chain has flushed its reset zeros
  assign hit  = arm & ((rise & rise_en) | (fall & fall_en));
  assign kind = synced ? KIND_RISE : KIND_FALL;

endmodule

// File: rtl/edge_event_scheduler.sv
// Collects per-channel edge events and serialises them round-robin onto a valid/ready port.
// Pending set SYNC_STAGES+1 cycles after an input change, presented one cycle later; output holds while stalled.
module edge_event_scheduler
  import edge_evt_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         sig_in,
  input  logic [2*N_CH-1:0]       edge_mode,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [$clog2(N_CH)-1:0] evt_ch,
  output logic                    evt_kind,
  output logic [N_CH-1:0]         overflow,
  input  logic [N_CH-1:0]         ovf_clr
);

  localparam int CH_W    = $clog2(N_CH);
  localparam int ARM_CNT = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_CNT + 1);

  logic [ARM_W-1:0] arm_cnt;
  logic             armed;
  logic [N_CH-1:0]  qual;
  logic [N_CH-1:0]  qual_kind;
  logic [N_CH-1:0]  mode_on;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  pend_kind;
  logic [N_CH-1:0]  eligible;
  logic [N_CH-1:0]  drain;
  logic [N_CH-1:0]  pending_nxt;
  logic [N_CH-1:0]  kind_nxt;
  logic [N_CH-1:0]  ovf_nxt;
  logic [CH_W-1:0]  ptr;
  logic [CH_W-1:0]  rr_idx [N_CH];
  logic [CH_W-1:0]  grant_idx;
  logic             grant_vld;
  logic             load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 1'b1;
    end
  end

  assign armed = (arm_cnt == ARM_W'(ARM_CNT));

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_qualifier #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_qual (
      .clk  (clk),
      .rst_n(rst_n),
      .sig  (sig_in[i]),
      .mode (edge_mode[2*i +: 2]),
      .arm  (armed),
      .hit  (qual[i]),
      .kind (qual_kind[i])
    );

    assign mode_on[i] = (edge_mode[2*i +: 2] != MODE_OFF);
    assign rr_idx[i]  = CH_W'(rr_wrap(int'(ptr), i, N_CH));
    assign drain[i]   = load & grant_vld & (grant_idx == CH_W'(i));
  end

  assign eligible = pending & mode_on;
  assign load     = ~evt_valid | evt_ready;

  // ptr is the first index searched, i.e. last grant + 1
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!grant_vld && eligible[rr_idx[k]]) begin
        grant_vld = 1'b1;
        grant_idx = rr_idx[k];
      end
    end
  end

  always_comb begin
    pending_nxt = pending;
    kind_nxt    = pend_kind;
    ovf_nxt     = overflow;
    for (int i = 0; i < N_CH; i++) begin
      if (!mode_on[i]) begin
        pending_nxt[i] = 1'b0;
      end else if (qual[i]) begin
        if (pending[i] && !drain[i]) begin
          ovf_nxt[i] = 1'b1;
        end else begin
          pending_nxt[i] = 1'b1;
          kind_nxt[i]    = qual_kind[i];
        end
      end else if (drain[i]) begin
        pending_nxt[i] = 1'b0;
      end
      if (ovf_clr[i]) begin
        ovf_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_kind  <= 1'b0;
      ptr       <= '0;
      pending   <= '0;
      pend_kind <= '0;
      overflow  <= '0;
    end else begin
      if (load) begin
        evt_valid <= grant_vld;
        if (grant_vld) begin
          evt_ch   <= grant_idx;
          evt_kind <= pend_kind[grant_idx];
          ptr      <= CH_W'(rr_wrap(int'(grant_idx), 1, N_CH));
        end
      end
      pending   <= pending_nxt;
      pend_kind <= kind_nxt;
      overflow  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Scoreboard bench for edge_event_scheduler: expected events queued at stimulus time,
// popped on every accepted handshake, plus direct timing/flag checks.
module tb_edge_event_scheduler;

  typedef struct packed {
    logic [1:0] ch;
    logic       kind;
  } evt_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] sig_in;
  logic [7:0] edge_mode;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_kind;
  logic [3:0] overflow;
  logic [3:0] ovf_clr;

  int   n_cmp = 0;
  int   n_err = 0;
  evt_t sb[$];

  edge_event_scheduler #(
    .N_CH(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .edge_mode(edge_mode),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_ch   (evt_ch),
    .evt_kind (evt_kind),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_evt(input logic [1:0] ch, input logic kind);
    evt_t e;
    e.ch   = ch;
    e.kind = kind;
    sb.push_back(e);
  endtask

  // Every accepted handshake must match the oldest expected event
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_evt", 32'({evt_ch, evt_kind}), 32'hFFFF);
      end else begin
        evt_t e;
        e = sb.pop_front();
        check_eq("sb_evt", 32'({evt_ch, evt_kind}), 32'({e.ch, e.kind}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    sig_in    = 4'h0;
    edge_mode = 8'h00;
    evt_ready = 1'b0;
    ovf_clr   = 4'h0;

    tick(3);
    check_eq("rst_valid", 32'(evt_valid), 0);
    check_eq("rst_ch", 32'(evt_ch), 0);
    check_eq("rst_kind", 32'(evt_kind), 0);
    check_eq("rst_ovf", 32'(overflow), 0);
    rst_n = 1'b1;
    tick(5);

    // All channels both-edge, simultaneous toggle: 0,1,2,3 back to back, twice
    edge_mode = 8'hFF;
    evt_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      sig_in = (b == 0) ? 4'hF : 4'h0;
      for (int k = 0; k < 4; k++) expect_evt(2'(k), (b == 0));
      tick(3);
      check_eq("rr_pre", 32'(evt_valid), 0);
      for (int k = 0; k < 4; k++) begin
        tick(1);
        check_eq("rr_valid", 32'(evt_valid), 1);
        check_eq("rr_ch", 32'(evt_ch), 32'(k));
        check_eq("rr_kind", 32'(evt_kind), (b == 0) ? 1 : 0);
      end
      tick(1);
      check_eq("rr_post", 32'(evt_valid), 0);
    end

    // Latency: ch1 rising, visible exactly 4 cycles after the change, one cycle wide
    edge_mode = 8'h04;
    sig_in[1] = 1'b1;
    expect_evt(2'd1, 1'b1);
    tick(3);
    check_eq("lat_early", 32'(evt_valid), 0);
    tick(1);
    check_eq("lat_valid", 32'(evt_valid), 1);
    check_eq("lat_ch", 32'(evt_ch), 1);
    check_eq("lat_kind", 32'(evt_kind), 1);
    tick(1);
    check_eq("lat_single", 32'(evt_valid), 0);

    // Overflow on ch2 falling-only with the consumer stalled
    edge_mode = 8'h20;
    evt_ready = 1'b0;
    sig_in[2] = 1'b1;
    tick(5);
    check_eq("fall_ignores_rise", 32'(evt_valid), 0);
    sig_in[2] = 1'b0;
    expect_evt(2'd2, 1'b0);
    tick(4);
    check_eq("hold_a", 32'({evt_valid, evt_ch, evt_kind}), 32'({1'b1, 2'd2, 1'b0}));
    sig_in[2] = 1'b1;
    tick(4);
    check_eq("hold_b", 32'({evt_valid, evt_ch, evt_kind}), 32'({1'b1, 2'd2, 1'b0}));
    sig_in[2] = 1'b0;
    expect_evt(2'd2, 1'b0);
    tick(4);
    check_eq("ovf_none_yet", 32'(overflow), 0);
    sig_in[2] = 1'b1;
    tick(4);
    sig_in[2] = 1'b0;
    tick(4);
    check_eq("hold_c", 32'({evt_valid, evt_ch, evt_kind}), 32'({1'b1, 2'd2, 1'b0}));
    check_eq("ovf_set", 32'(overflow), 32'h4);
    ovf_clr = 4'h4;
    tick(1);
    ovf_clr = 4'h0;
    check_eq("ovf_clr", 32'(overflow), 0);
    evt_ready = 1'b1;
    tick(3);
    check_eq("drain_idle", 32'(evt_valid), 0);
    check_eq("drain_sb_empty", 32'(sb.size()), 0);

    // Disabling ch0 drops its pending edge; the presented one still goes out
    edge_mode = 8'h01;
    evt_ready = 1'b0;
    sig_in[0] = 1'b1;
    expect_evt(2'd0, 1'b1);
    tick(4);
    check_eq("off_presented", 32'({evt_valid, evt_ch}), 32'({1'b1, 2'd0}));
    sig_in[0] = 1'b0;
    tick(4);
    sig_in[0] = 1'b1;
    tick(4);
    edge_mode = 8'h00;
    tick(2);
    evt_ready = 1'b1;
    tick(1);
    edge_mode = 8'h01;
    tick(4);
    check_eq("off_no_stale", 32'(evt_valid), 0);
    check_eq("off_sb_empty", 32'(sb.size()), 0);
    check_eq("off_no_ovf", 32'(overflow), 0);

    // Reset while an event is presented and stalled
    edge_mode = 8'h40;
    evt_ready = 1'b0;
    sig_in[3] = 1'b1;
    tick(5);
    check_eq("abort_pre", 32'({evt_valid, evt_ch, evt_kind}), 32'({1'b1, 2'd3, 1'b1}));
    rst_n = 1'b0;
    #1;
    check_eq("abort_valid", 32'(evt_valid), 0);
    check_eq("abort_ch", 32'(evt_ch), 0);
    check_eq("abort_kind", 32'(evt_kind), 0);
    check_eq("abort_ovf", 32'(overflow), 0);

    // Static-high inputs through reset release raise nothing
    sig_in    = 4'hF;
    edge_mode = 8'hFF;
    evt_ready = 1'b1;
    tick(3);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check_eq("no_spurious", 32'(evt_valid), 0);
    end
    sig_in[0] = 1'b0;
    expect_evt(2'd0, 1'b0);
    tick(6);
    check_eq("post_arm_sb_empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
